// File: rtl/io_disp_pkg.sv
// Shared constants and types for the decimal output-port display stage.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package io_disp_pkg;

   localparam int OVF_LIMIT = 999999;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000   // 9
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_UPDATE = 2'd2
   } disp_state_t;

   // Double-dabble correction applied to each BCD nibble before a shift.
   function automatic logic [3:0] add3_nibble(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

endpackage

// File: rtl/io_bcd_display_seg7_decode.sv
// One BCD digit to an active-low 7-segment pattern; blank or non-decimal
// input turns every segment off.
module seg7_decode
   import io_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && (digit <= 4'd9)) begin
         seg = SEG_DIGIT[digit];
      end
   end

endmodule

// File: rtl/io_bcd_display.sv
// Output-port display stage: binary write -> iterative double-dabble ->
// six decimal 7-segment digits, with a one-deep pending write slot.
module io_bcd_display
   import io_disp_pkg::*;
#(
   parameter int BIN_W    = 20,
   parameter int DIGITS   = 6,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [23:0] bcd_out,
   output logic [6:0]  dt0,
   output logic [6:0]  dt1,
   output logic [6:0]  dt2,
   output logic [6:0]  dt3,
   output logic [6:0]  dt4,
   output logic [6:0]  dt5
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W);

   // Handshake: wr_en is a single-cycle strobe with no back-pressure; a
   // write that lands while busy is parked in the pending slot (newest wins)
   // and done pulses for one cycle each time the displays are reloaded.

   disp_state_t        state;
   logic [BIN_W-1:0]   bin_sr;
   logic [BCD_W-1:0]   bcd_acc;
   logic [BCD_W-1:0]   bcd_adj;
   logic [CNT_W-1:0]   bit_cnt;
   logic               ovf_cap;
   logic               pend_valid;
   logic [BIN_W-1:0]   pend_data;
   logic               start_go;
   logic [BIN_W-1:0]   start_val;
   logic               start_ovf;
   logic [DIGITS-1:0]  blank_dig;
   logic [6:0]         seg_dec [DIGITS];
   logic [6:0]         dt_q    [DIGITS];
   logic               unused_upper_bits;

   assign unused_upper_bits = ^wr_data[31:BIN_W];

   assign busy = (state != ST_IDLE);
   assign dt0  = dt_q[0];
   assign dt1  = dt_q[1];
   assign dt2  = dt_q[2];
   assign dt3  = dt_q[3];
   assign dt4  = dt_q[4];
   assign dt5  = dt_q[5];

   // A write in UPDATE supersedes any older pending value and starts at once.
   always_comb begin
      start_go  = 1'b0;
      start_val = wr_data[BIN_W-1:0];
      case (state)
         ST_IDLE: start_go = wr_en;
         ST_UPDATE: begin
            start_go  = wr_en | pend_valid;
            start_val = wr_en ? wr_data[BIN_W-1:0] : pend_data;
         end
         default: start_go = 1'b0;
      endcase
      start_ovf = (32'(start_val) > 32'(OVF_LIMIT));
   end

   always_comb begin
      bcd_adj = '0;
      for (int k = 0; k < DIGITS; k++) begin
         bcd_adj[4*k +: 4] = add3_nibble(bcd_acc[4*k +: 4]);
      end
   end

   // Digit k>0 is blank only while it and every digit above it are zero.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      blank_dig  = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above   = zero_above & (bcd_acc[4*k +: 4] == 4'd0);
         blank_dig[k] = BLANK_LZ & zero_above;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      seg7_decode u_dec (
         .digit (bcd_acc[4*g +: 4]),
         .blank (blank_dig[g]),
         .seg   (seg_dec[g])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         done       <= 1'b0;
         ovf        <= 1'b0;
         bcd_out    <= '0;
         bin_sr     <= '0;
         bcd_acc    <= '0;
         bit_cnt    <= '0;
         ovf_cap    <= 1'b0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         for (int k = 0; k < DIGITS; k++) begin
            dt_q[k] <= ((k == 0) || !BLANK_LZ) ? SEG_DIGIT[0] : SEG_BLANK;
         end
      end else begin
         done <= 1'b0;
         if (start_go) begin
            bin_sr  <= start_val;
            bcd_acc <= '0;
            bit_cnt <= CNT_W'(BIN_W - 1);
            ovf_cap <= start_ovf;
         end
         case (state)
            ST_IDLE: begin
               if (start_go) state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (wr_en) begin
                  pend_valid <= 1'b1;
                  pend_data  <= wr_data[BIN_W-1:0];
               end
               bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
               bin_sr  <= bin_sr << 1;
               bit_cnt <= bit_cnt - 1'b1;
               if (bit_cnt == '0) state <= ST_UPDATE;
            end
            ST_UPDATE: begin
               done       <= 1'b1;
               ovf        <= ovf_cap;
               bcd_out    <= ovf_cap ? '1 : bcd_acc;
               pend_valid <= 1'b0;
               for (int k = 0; k < DIGITS; k++) begin
                  dt_q[k] <= ovf_cap ? SEG_DASH : seg_dec[k];
               end
               state <= start_go ? ST_SHIFT : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_bcd_display.sv
// Randomised bench for io_bcd_display: an arithmetic decimal/segment model
// feeds an expected queue that is drained on every done pulse.
module tb_io_bcd_display;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [31:0] wr_data;

   logic        busy, done, ovf;
   logic [23:0] bcd_out;
   logic [6:0]  dt0, dt1, dt2, dt3, dt4, dt5;
   logic        nb_busy, nb_done, nb_ovf;
   logic [23:0] nb_bcd_out;
   logic [6:0]  nb_dt0, nb_dt1, nb_dt2, nb_dt3, nb_dt4, nb_dt5;

   int err_cnt  = 0;
   int chk_cnt  = 0;
   int done_cnt = 0;
   logic [19:0] exp_q[$];

   io_bcd_display #(.BIN_W(20), .DIGITS(6), .BLANK_LZ(1'b1)) dut (
      .clock(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .busy(busy), .done(done), .ovf(ovf), .bcd_out(bcd_out),
      .dt0(dt0), .dt1(dt1), .dt2(dt2), .dt3(dt3), .dt4(dt4), .dt5(dt5)
   );

   io_bcd_display #(.BIN_W(20), .DIGITS(6), .BLANK_LZ(1'b0)) dut_nb (
      .clock(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .busy(nb_busy), .done(nb_done), .ovf(nb_ovf), .bcd_out(nb_bcd_out),
      .dt0(nb_dt0), .dt1(nb_dt1), .dt2(nb_dt2), .dt3(nb_dt3), .dt4(nb_dt4), .dt5(nb_dt5)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic logic [23:0] model_bcd(input int v);
      logic [23:0] r;
      int p;
      if (v > 999999) return 24'hFFFFFF;
      r = '0;
      p = 1;
      for (int k = 0; k < 6; k++) begin
         r = r | (24'((v / p) % 10) << (4 * k));
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [41:0] model_disp(input int v, input bit blz);
      logic [41:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < 6; k++) begin
         if (v > 999999)              r[7*k +: 7] = 7'b0111111;
         else if (blz && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
         else                         r[7*k +: 7] = seg_of((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!reset && (done || nb_done)) begin
         done_cnt++;
         check("done_pair", {63'd0, nb_done}, {63'd0, done});
         if (exp_q.size() == 0) begin
            check("spurious_done", {63'd0, done}, 64'd0);
         end else begin
            int v;
            v = int'(exp_q.pop_front());
            check("bcd_out",    64'(bcd_out), 64'(model_bcd(v)));
            check("ovf",        64'(ovf), 64'(v > 999999));
            check("disp_blz",   64'({dt5, dt4, dt3, dt2, dt1, dt0}), 64'(model_disp(v, 1'b1)));
            check("disp_noblz", 64'({nb_dt5, nb_dt4, nb_dt3, nb_dt2, nb_dt1, nb_dt0}),
                  64'(model_disp(v, 1'b0)));
            check("bcd_out_nb", 64'(nb_bcd_out), 64'(model_bcd(v)));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic write_val(input logic [31:0] v);
      wr_en   = 1'b1;
      wr_data = v;
      @(negedge clk);
      wr_en   = 1'b0;
      wr_data = $urandom;
   endtask

   task automatic wait_dones(input string tag, input int target, input int bound);
      int n;
      n = 0;
      while (done_cnt < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check(tag, 64'(done_cnt), 64'(target));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, {62'd0, nb_busy, busy}, 64'd0);
      check({tag, "_done"}, {62'd0, nb_done, done}, 64'd0);
      check({tag, "_ovf"},  {62'd0, nb_ovf, ovf}, 64'd0);
      check({tag, "_bcd"},  {16'd0, nb_bcd_out, bcd_out}, 64'd0);
      check({tag, "_dt_blz"}, 64'({dt5, dt4, dt3, dt2, dt1, dt0}),
            64'({{5{7'b1111111}}, 7'b1000000}));
      check({tag, "_dt_noblz"}, 64'({nb_dt5, nb_dt4, nb_dt3, nb_dt2, nb_dt1, nb_dt0}),
            64'({6{7'b1000000}}));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, busy_n, base;
      logic [31:0] v, a, b;

      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");

      // 123456: latency and busy length
      exp_q.push_back(20'd123456);
      write_val(32'd123456);
      n = 0;
      busy_n = 0;
      while (!done && n < 100) begin
         if (busy) busy_n++;
         @(negedge clk);
         n++;
      end
      check("latency_123456", 64'(n), 64'd21);
      check("busy_len_123456", 64'(busy_n), 64'd21);
      check("bcd_123456", 64'(bcd_out), 64'h123456);
      @(negedge clk);
      check("busy_after", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);

      // 7: leading-zero blanking on and off
      base = done_cnt;
      exp_q.push_back(20'd7);
      write_val(32'd7);
      wait_dones("dones_7", base + 1, 100);
      check("dt0_7", 64'(dt0), 64'b1111000);
      check("dt_hi_blz_7", 64'({dt5, dt4, dt3, dt2, dt1}), 64'({5{7'b1111111}}));
      check("dt_hi_noblz_7", 64'({nb_dt5, nb_dt4, nb_dt3, nb_dt2, nb_dt1}), 64'({5{7'b1000000}}));

      // overflow with upper bits set
      base = done_cnt;
      exp_q.push_back(20'hFF000);
      write_val(32'hFFFF_F000);
      wait_dones("dones_ovf", base + 1, 100);
      check("ovf_flag", 64'(ovf), 64'd1);
      check("ovf_bcd", 64'(bcd_out), 64'hFFFFFF);

      // pending: newest wins
      base = done_cnt;
      exp_q.push_back(20'd11);
      exp_q.push_back(20'd33);
      write_val(32'd11);
      repeat (3) @(negedge clk);
      write_val(32'd22);
      repeat (3) @(negedge clk);
      write_val(32'd33);
      wait_dones("dones_pend", base + 2, 200);
      repeat (30) @(negedge clk);
      check("pend_total", 64'(done_cnt - base), 64'd2);

      // write landing in the UPDATE cycle
      base = done_cnt;
      a = 32'($urandom_range(0, 999999));
      b = 32'($urandom_range(0, 999999));
      exp_q.push_back(a[19:0]);
      exp_q.push_back(b[19:0]);
      write_val(a);
      repeat (20) @(negedge clk);
      check("pre_update_done", 64'(done), 64'd0);
      write_val(b);
      check("update_done", 64'(done), 64'd1);
      wait_dones("dones_upd", base + 2, 200);

      // random values, some overflowing, upper bits random
      for (int i = 0; i < 16; i++) begin
         base = done_cnt;
         if ($urandom_range(0, 3) == 0) v = $urandom;
         else v = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 999999));
         exp_q.push_back(v[19:0]);
         write_val(v);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         wait_dones("dones_rand", base + 1, 100);
      end

      // reset mid-conversion
      base = done_cnt;
      write_val(32'd999999);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("midrst");
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("midrst_no_done", 64'(done_cnt - base), 64'd0);

      base = done_cnt;
      exp_q.push_back(20'd42);
      write_val(32'd42);
      wait_dones("dones_42", base + 1, 100);
      check("bcd_42", 64'(bcd_out), 64'h000042);

      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
